// File: rtl/apb_req_arbiter.sv
// Arbitrates NUM_REQ CSR requesters onto one APB master CSR port, one transfer at a time.
// Define APB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module apb_req_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                          pclk_i,
   input  logic                          prstn_i,
   input  logic [NUM_REQ-1:0]            req_i,
   input  logic [NUM_REQ-1:0]            req_write_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]            ack_o,
   output logic [DATA_WIDTH-1:0]         rdata_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic [ADDR_WIDTH-1:0]         reg_addr_o,
   output logic [DATA_WIDTH-1:0]         reg_wdata_o,
   output logic                          reg_write_o,
   output logic                          reg_enable_o,
   input  logic                          reg_idle_i,
   input  logic [DATA_WIDTH-1:0]         reg_rdata_i,
   output logic [2:0]                    dbg_state
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_LAUNCH     = 3'd1,
      S_WAIT_START = 3'd2,
      S_WAIT_DONE  = 3'd3,
      S_RESP       = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [IDXW-1:0]         start_idx;
   logic [IDXW-1:0]         win_d;
   logic [NUM_REQ-1:0]      win_oh;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic                    sel_write;
   logic                    launch;

   // First set request at or after 'start', wrapping around.
   function automatic logic [IDXW-1:0] pick(input logic [NUM_REQ-1:0] req,
                                            input logic [IDXW-1:0]    start);
      logic [IDXW-1:0] w;
      logic            found;
      int              idx;
      w     = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(start) + i) % NUM_REQ;
         if (!found && req[idx]) begin
            w     = IDXW'(idx);
            found = 1'b1;
         end
      end
      return w;
   endfunction

`ifdef APB_ARB_ROUND_ROBIN_EN
   logic [IDXW-1:0] ptr_q;
   logic [IDXW-1:0] last_q;

   // Pointer advances past the winner only once its transfer completes.
   always_ff @(posedge pclk_i or negedge prstn_i) begin
      if (!prstn_i) begin
         ptr_q  <= '0;
         last_q <= '0;
      end else begin
         if (state_q == S_IDLE && launch) last_q <= win_d;
         if (state_q == S_RESP)
            ptr_q <= (last_q == IDXW'(NUM_REQ - 1)) ? '0 : last_q + 1'b1;
      end
   end
   assign start_idx = ptr_q;
`else
   assign start_idx = '0;
`endif

   assign launch = (|req_i) && reg_idle_i;
   assign win_d  = pick(req_i, start_idx);

   always_comb begin
      win_oh    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      sel_write = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win_d == IDXW'(k)) begin
            win_oh[k] = 1'b1;
            sel_addr  = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            sel_write = req_write_i[k];
         end
      end
   end

   always_ff @(posedge pclk_i or negedge prstn_i) begin
      if (!prstn_i) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:       if (launch) state_d = S_LAUNCH;
         S_LAUNCH:     state_d = S_WAIT_START;
         S_WAIT_START: if (!reg_idle_i) state_d = S_WAIT_DONE;
         S_WAIT_DONE:  if (reg_idle_i) state_d = S_RESP;
         S_RESP:       state_d = S_IDLE;
         default:      state_d = S_IDLE;
      endcase
   end

   // Transfer fields are latched once at grant and held until the next grant.
   always_ff @(posedge pclk_i or negedge prstn_i) begin
      if (!prstn_i) begin
         grant_o     <= '0;
         ack_o       <= '0;
         rdata_o     <= '0;
         reg_addr_o  <= '0;
         reg_wdata_o <= '0;
         reg_write_o <= 1'b0;
      end else begin
         ack_o <= '0;
         case (state_q)
            S_IDLE: begin
               if (launch) begin
                  grant_o     <= win_oh;
                  reg_addr_o  <= sel_addr;
                  reg_wdata_o <= sel_wdata;
                  reg_write_o <= sel_write;
               end
            end
            S_WAIT_DONE: begin
               if (reg_idle_i) begin
                  rdata_o <= reg_rdata_i;
                  ack_o   <= grant_o;
               end
            end
            S_RESP:  grant_o <= '0;
            default: ;
         endcase
      end
   end

   // The APB master is edge-triggered on enable, so this is a single-cycle pulse.
   assign reg_enable_o = (state_q == S_LAUNCH);
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a behavioural APB master model (configurable wait states).
module tb_apb_req_arbiter;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic              pclk_i = 1'b0;
   logic              prstn_i = 1'b0;
   logic [NR-1:0]     req_i = '0;
   logic [NR-1:0]     req_write_i = '0;
   logic [NR*AW-1:0]  req_addr_i = '0;
   logic [NR*DW-1:0]  req_wdata_i = '0;
   logic [NR-1:0]     ack_o;
   logic [DW-1:0]     rdata_o;
   logic [NR-1:0]     grant_o;
   logic [AW-1:0]     reg_addr_o;
   logic [DW-1:0]     reg_wdata_o;
   logic              reg_write_o;
   logic              reg_enable_o;
   logic              reg_idle_i;
   logic [DW-1:0]     reg_rdata_i = '0;
   logic [2:0]        dbg_state;

   int vectors = 0;
   int fails = 0;

   // clock / reset
   always #5 pclk_i = ~pclk_i;

   apb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .pclk_i(pclk_i), .prstn_i(prstn_i), .req_i(req_i), .req_write_i(req_write_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .ack_o(ack_o), .rdata_o(rdata_o),
      .grant_o(grant_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
      .reg_write_o(reg_write_o), .reg_enable_o(reg_enable_o), .reg_idle_i(reg_idle_i),
      .reg_rdata_i(reg_rdata_i), .dbg_state(dbg_state)
   );

   // APB master model: busy for setup + (1 + wait_states) access cycles after an enable.
   logic busy;
   int   left;
   int   wait_states = 0;
   logic hold_off = 1'b0;
   assign reg_idle_i = !busy && !hold_off;

   always @(posedge pclk_i or negedge prstn_i) begin
      if (!prstn_i) begin
         busy <= 1'b0;
         left <= 0;
      end else if (!busy && reg_enable_o) begin
         busy <= 1'b1;
         left <= 1 + wait_states;
      end else if (busy) begin
         if (left == 0) busy <= 1'b0;
         else           left <= left - 1;
      end
   end

   // Protocol monitor: one-hot ack/grant and no back-to-back enable.
   int   en_count = 0;
   logic en_prev = 1'b0;
   always @(negedge pclk_i) begin
      if (!prstn_i) begin
         en_prev = 1'b0;
      end else begin
         vectors++;
         if ($countones(ack_o) > 1 || $countones(grant_o) > 1 || (reg_enable_o && en_prev)) begin
            fails++;
            $display("FAIL protocol ack=%b grant=%b en=%b prev_en=%b (need <=1 hot, no consecutive enable)",
                     ack_o, grant_o, reg_enable_o, en_prev);
         end
         if (reg_enable_o) en_count++;
         en_prev = reg_enable_o;
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge pclk_i);
      #1;
   endtask

   task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_write_i[k]          = wr;
      req_addr_i[k*AW +: AW]  = a;
      req_wdata_i[k*DW +: DW] = d;
   endtask

   // Cycle count includes the cycle in which the request was first presented.
   task automatic wait_ack(input int start, output int cycles, output logic [NR-1:0] ackv);
      cycles = start;
      ackv   = '0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         cycles++;
         if (ack_o != '0) begin
            ackv = ack_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      prstn_i = 1'b0;
      repeat (3) cyc();
      vectors++; if (ack_o !== '0)       begin fails++; $display("FAIL rst_ack got=%b exp=0", ack_o); end
      vectors++; if (grant_o !== '0)     begin fails++; $display("FAIL rst_grant got=%b exp=0", grant_o); end
      vectors++; if (rdata_o !== '0)     begin fails++; $display("FAIL rst_rdata got=%h exp=0", rdata_o); end
      vectors++; if (reg_addr_o !== '0)  begin fails++; $display("FAIL rst_addr got=%h exp=0", reg_addr_o); end
      vectors++; if (reg_wdata_o !== '0) begin fails++; $display("FAIL rst_wdata got=%h exp=0", reg_wdata_o); end
      vectors++; if (reg_write_o !== 1'b0) begin fails++; $display("FAIL rst_write got=%b exp=0", reg_write_o); end
      vectors++; if (reg_enable_o !== 1'b0) begin fails++; $display("FAIL rst_enable got=%b exp=0", reg_enable_o); end
      vectors++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
      prstn_i = 1'b1;
      cyc();
   endtask

   task automatic test_single_read();
      int c; logic [NR-1:0] a;
      reg_rdata_i = 32'hDEAD_BEEF; wait_states = 0; en_count = 0;
      set_req(0, 1'b0, 32'h100, 32'h0);
      req_i = 4'b0001;
      wait_ack(1, c, a);
      req_i = '0;
      vectors++; if (a !== 4'b0001) begin fails++; $display("FAIL rd_ack got=%b exp=0001", a); end
      vectors++; if (c !== 6) begin fails++; $display("FAIL rd_latency got=%0d exp=6", c); end
      vectors++; if (rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data got=%h exp=deadbeef", rdata_o); end
      vectors++; if (reg_addr_o !== 32'h100) begin fails++; $display("FAIL rd_addr got=%h exp=100", reg_addr_o); end
      vectors++; if (grant_o !== 4'b0001) begin fails++; $display("FAIL rd_grant_resp got=%b exp=0001", grant_o); end
      vectors++; if (en_count !== 1) begin fails++; $display("FAIL rd_enable_pulses got=%0d exp=1", en_count); end
      reg_rdata_i = 32'h1111_2222;
      cyc();
      vectors++; if (grant_o !== '0) begin fails++; $display("FAIL rd_grant_idle got=%b exp=0", grant_o); end
      vectors++; if (dbg_state !== 3'd0) begin fails++; $display("FAIL rd_state_idle got=%0d exp=0", dbg_state); end
      vectors++; if (rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data_hold got=%h exp=deadbeef", rdata_o); end
   endtask

   task automatic test_single_write();
      int c; logic [NR-1:0] a;
      wait_states = 0; c = 1; a = '0;
      set_req(2, 1'b1, 32'h40, 32'h1234_5678);
      req_i = 4'b0100;
      for (int i = 0; i < 40; i++) begin
         cyc();
         c++;
         vectors++;
         if (reg_write_o !== 1'b1 || reg_wdata_o !== 32'h1234_5678 || reg_addr_o !== 32'h40) begin
            fails++;
            $display("FAIL wr_stable cyc=%0d write=%b wdata=%h addr=%h exp 1/12345678/40", c, reg_write_o, reg_wdata_o, reg_addr_o);
         end
         if (ack_o != '0) begin a = ack_o; break; end
      end
      req_i = '0;
      vectors++; if (a !== 4'b0100) begin fails++; $display("FAIL wr_ack got=%b exp=0100", a); end
      vectors++; if (c !== 6) begin fails++; $display("FAIL wr_latency got=%0d exp=6", c); end
      cyc();
   endtask

   task automatic test_wait_states();
      int c; logic [NR-1:0] a;
      reg_rdata_i = 32'hA5A5_0003; wait_states = 3; en_count = 0;
      set_req(3, 1'b0, 32'h2C, 32'h0);
      req_i = 4'b1000;
      wait_ack(1, c, a);
      req_i = '0;
      vectors++; if (a !== 4'b1000) begin fails++; $display("FAIL ws_ack got=%b exp=1000", a); end
      vectors++; if (c !== 9) begin fails++; $display("FAIL ws_latency got=%0d exp=9", c); end
      vectors++; if (en_count !== 1) begin fails++; $display("FAIL ws_enable_pulses got=%0d exp=1", en_count); end
      vectors++; if (rdata_o !== 32'hA5A5_0003) begin fails++; $display("FAIL ws_data got=%h exp=a5a50003", rdata_o); end
      wait_states = 0;
      cyc();
   endtask

   task automatic test_master_busy();
      int c; logic [NR-1:0] a;
      reg_rdata_i = 32'h0000_0B0B; en_count = 0; hold_off = 1'b1;
      set_req(1, 1'b0, 32'h80, 32'h0);
      req_i = 4'b0010;
      repeat (4) cyc();
      vectors++; if (grant_o !== '0 || dbg_state !== 3'd0) begin
         fails++; $display("FAIL busy_hold grant=%b state=%0d exp 0/0", grant_o, dbg_state);
      end
      vectors++; if (en_count !== 0) begin fails++; $display("FAIL busy_enable got=%0d exp=0", en_count); end
      hold_off = 1'b0;
      wait_ack(1, c, a);
      req_i = '0;
      vectors++; if (a !== 4'b0010) begin fails++; $display("FAIL busy_ack got=%b exp=0010", a); end
      vectors++; if (c !== 6) begin fails++; $display("FAIL busy_latency got=%0d exp=6", c); end
      cyc();
   endtask

   task automatic test_early_drop();
      int c; logic [NR-1:0] a;
      reg_rdata_i = 32'h0000_00E1;
      set_req(0, 1'b0, 32'h10, 32'h0);
      req_i = 4'b0001;
      cyc(); cyc();
      req_i = '0;
      wait_ack(3, c, a);
      vectors++; if (a !== 4'b0001) begin fails++; $display("FAIL drop_ack got=%b exp=0001", a); end
      vectors++; if (c !== 6) begin fails++; $display("FAIL drop_latency got=%0d exp=6", c); end
      vectors++; if (rdata_o !== 32'h0000_00E1) begin fails++; $display("FAIL drop_data got=%h exp=000000e1", rdata_o); end
      cyc();
   endtask

   task automatic test_contention();
      int c; logic [NR-1:0] a;
      logic [NR-1:0] exp_q[$];
      logic [NR-1:0] e;
      for (int k = 0; k < NR; k++) set_req(k, 1'b0, 32'h200 + 32'(k * 4), 32'h0);
`ifdef APB_ARB_ROUND_ROBIN_EN
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
      req_i = 4'b1111;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         wait_ack(1, c, a);
         vectors++; if (a !== e) begin fails++; $display("FAIL arb_order got=%b exp=%b", a, e); end
`ifndef APB_ARB_ROUND_ROBIN_EN
         req_i = req_i & ~e;
`endif
      end
      req_i = '0;
      cyc();
   endtask

   task automatic test_reset_mid();
      int c; logic [NR-1:0] a;
      reg_rdata_i = 32'h7777_7777; wait_states = 3;
      set_req(0, 1'b0, 32'h300, 32'h0);
      req_i = 4'b0001;
      for (int i = 0; i < 20; i++) begin
         if (dbg_state == 3'd3) break;
         cyc();
      end
      vectors++; if (dbg_state !== 3'd3) begin fails++; $display("FAIL midrst_reach got=%0d exp=3", dbg_state); end
      prstn_i = 1'b0;
      #1;
      vectors++; if ({ack_o, grant_o, reg_enable_o, reg_write_o} !== '0 || rdata_o !== '0 ||
                     reg_addr_o !== '0 || reg_wdata_o !== '0 || dbg_state !== 3'd0) begin
         fails++;
         $display("FAIL midrst_outputs ack=%b grant=%b en=%b wr=%b rdata=%h addr=%h wdata=%h st=%0d exp all 0",
                  ack_o, grant_o, reg_enable_o, reg_write_o, rdata_o, reg_addr_o, reg_wdata_o, dbg_state);
      end
      req_i = '0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         vectors++; if (ack_o !== '0) begin fails++; $display("FAIL midrst_noack got=%b exp=0", ack_o); end
      end
      prstn_i = 1'b1;
      wait_states = 0;
      cyc();
      reg_rdata_i = 32'h0BAD_F00D;
      set_req(1, 1'b0, 32'h304, 32'h0);
      req_i = 4'b0010;
      wait_ack(1, c, a);
      req_i = '0;
      vectors++; if (a !== 4'b0010) begin fails++; $display("FAIL midrst_after_ack got=%b exp=0010", a); end
      vectors++; if (c !== 6) begin fails++; $display("FAIL midrst_after_latency got=%0d exp=6", c); end
      vectors++; if (rdata_o !== 32'h0BAD_F00D) begin fails++; $display("FAIL midrst_after_data got=%h exp=0badf00d", rdata_o); end
      cyc();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_wait_states();
      test_master_busy();
      test_early_drop();
      test_contention();
      test_reset_mid();
      repeat (2) cyc();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, transfer address width.
REQ-003 SHALL provide parameter DATA_WIDTH, default 32, transfer data width.
REQ-004 SHALL have port pclk_i  input  1  clock; all logic on its rising edge.
REQ-005 SHALL have port prstn_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_i  input  NUM_REQ  per-requester transfer request, level, held until ack.
REQ-007 SHALL have port req_write_i  input  NUM_REQ  per-requester 1=write, 0=read.
REQ-008 SHALL have port req_addr_i  input  NUM_REQ*ADDR_WIDTH  packed addresses; slice k belongs to requester k.
REQ-009 SHALL have port req_wdata_i  input  NUM_REQ*DATA_WIDTH  packed write data; slice k belongs to requester k.
REQ-010 SHALL have port ack_o  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rdata_o  output  DATA_WIDTH  read data; valid in the ack_o cycle.
REQ-012 SHALL have port grant_o  output  NUM_REQ  one-hot current owner; all-zero when idle.
REQ-013 SHALL have port reg_addr_o  output  ADDR_WIDTH  address to the APB master CSR port.
REQ-014 SHALL have port reg_wdata_o  output  DATA_WIDTH  write data to the APB master.
REQ-015 SHALL have port reg_write_o  output  1  direction to the APB master.
REQ-016 SHALL have port reg_enable_o  output  1  one-cycle start pulse to the APB master.
REQ-017 SHALL have port reg_idle_i  input  1  APB master FSM idle.
REQ-018 SHALL have port reg_rdata_i  input  DATA_WIDTH  APB master read data.

Function
REQ-019 SHALL implement FSM states IDLE, LAUNCH, WAIT_START, WAIT_DONE, RESP.
REQ-020 IDLE: when any req_i bit is set and reg_idle_i=1, SHALL select a winner, register its addr/wdata/write onto reg_*_o, set grant_o, and go to LAUNCH; otherwise stay in IDLE.
REQ-021 LAUNCH: reg_enable_o=1 for exactly this cycle; next state WAIT_START.
REQ-022 WAIT_START: reg_enable_o=0; on reg_idle_i=0 go to WAIT_DONE; otherwise stay.
REQ-023 WAIT_DONE: on reg_idle_i=1, capture reg_rdata_i into rdata_o and go to RESP.
REQ-024 RESP: ack_o[winner]=1 for exactly this cycle, grant_o cleared on exit; next state IDLE.
REQ-025 reg_enable_o SHALL never be high in two consecutive cycles, because the APB master detects rising edges only.
REQ-026 reg_addr_o, reg_wdata_o and reg_write_o SHALL stay stable from LAUNCH through RESP.
REQ-027 Minimum request-to-ack latency SHALL be 6 cycles with a zero-wait slave (IDLE, LAUNCH, WAIT_START, two master cycles, RESP); each slave wait state adds 1 cycle.
REQ-028 The granted requester SHALL drop req_i by the cycle after ack_o; the block SHALL NOT re-arbitrate until IDLE.
REQ-029 A req_i that deasserts before ack_o SHALL NOT abort the transfer; the transfer completes and ack_o still pulses.
REQ-030 Requests arriving in non-IDLE states SHALL be held pending and arbitrated at the next IDLE.
REQ-031 rdata_o SHALL hold its value until the next RESP; it is updated for writes as well, with don't-care content.
REQ-032 At most one ack_o bit and one grant_o bit SHALL be set in any cycle.

Reset
REQ-033 On prstn_i low: state=IDLE; ack_o, grant_o, rdata_o, reg_addr_o, reg_wdata_o, reg_write_o and reg_enable_o all 0; round-robin pointer=0.
REQ-034 Reset mid-transfer SHALL abandon the transfer with no ack_o; the requester re-requests.

Configuration
REQ-035 Macro APB_ARB_ROUND_ROBIN_EN defined: round-robin arbitration; search starts at (last winner+1) mod NUM_REQ; pointer updates in RESP.
REQ-036 Macro undefined: fixed priority, lowest index wins; no pointer register.

Verification
REQ-037 Single read: req_i=4'b0001, addr=0x100, slave returns 0xDEADBEEF with pready=1 -> one reg_enable_o pulse, ack_o=4'b0001 6 cycles after request, rdata_o=0xDEADBEEF.
REQ-038 Single write: req 2, wdata=0x12345678, addr=0x40 -> reg_write_o=1 and reg_wdata_o=0x12345678 stable through RESP; ack_o=4'b0100.
REQ-039 All four requesters asserted continuously with RR_EN -> grant order 0,1,2,3,0; without RR_EN -> 0,1,2,3 as each drops.
REQ-040 Slave inserts 3 wait states -> ack_o 9 cycles after request; reg_enable_o high exactly 1 cycle.
REQ-041 prstn_i asserted during WAIT_DONE -> all outputs 0 next cycle, no ack_o; a new request after reset completes normally.
